force_pair_scheduler: RTL
=========================

// Module: force_pair_scheduler
// PURPOSE
//  Round-robin scheduler sharing the single LJ force pipeline between N_REQ pair-filter requesters.
//  Sends at most one pair word per cycle into the pipeline and fills idle slots with null words.
//  Tracks in-flight pairs so pipe_out_valid lines up with force words leaving the pipeline.
//  Pulses cell_done once every requester has finished and the pipeline has drained.
// PARAMETERS
//  N_REQ     4    number of pair-filter requesters (>=1)
//  PIPE_LAT  1    cycles from pipe_in register update to matching pipeline output sample
//  PAIR_W    227  pair word width: [0+:96] ref pos, [96+:17] ref id, [113+:96] nbr pos,
//                 [209+:17] nbr id, [226] null flag
// PORTS
//  clk             in   1             posedge clock
//  reset           in   1             reset, asynchronous, active-high
//  start           in   1             begin a cell; sampled only in IDLE
//  req_valid       in   N_REQ         requester i presents a pair
//  req_last        in   N_REQ         requester i has no pairs beyond the current one (or none at all)
//  req_pair        in   N_REQ*PAIR_W  pair words; requester i uses [i*PAIR_W +: PAIR_W]
//  req_ready       out  N_REQ         one-hot grant; combinational from state, fin, valid and rr pointer
//  pipe_in         out  PAIR_W        registered word driven into the force pipeline
//  pipe_in_valid   out  1             registered; pipe_in carries a real pair
//  pipe_out_valid  out  1             pipeline output carries a valid force word this cycle
//  busy            out  1             state != IDLE
//  cell_done       out  1             one-cycle pulse at end of cell
// BEHAVIOUR
//  Null word: {1'b1, 226'b0}.
//  Reset values: pipe_in = null word; pipe_in_valid, pipe_out_valid, cell_done = 0; busy = 0.
//  Reset also clears fin[], the valid shift register and the rr pointer (ptr = N_REQ-1), and returns to IDLE.
//  Reset during any state drops all in-flight tracking; no cell_done is issued for that cell.
//  FSM: IDLE -> RUN on start.
//   - Entering RUN clears fin[].
//   - RUN -> DRAIN in the cycle after fin becomes all-ones.
//   - DRAIN -> DONE when vsr == 0.
//   - DONE -> IDLE unconditionally; cell_done = 1 only while in DONE.
//  RUN arbitration: eligible[i] = req_valid[i] & ~fin[i]. Search starts at ptr+1 mod N_REQ and grants the first eligible g.
//   - req_ready[g] = 1 in the same cycle.
//   - Next edge: pipe_in <= req_pair[g] with bit 226 forced to 0; pipe_in_valid <= 1; ptr <= g.
//   - No eligible requester: pipe_in <= null word; pipe_in_valid <= 0; ptr unchanged.
//  fin[i] sets on (req_ready[i] & req_last[i]), or on (req_last[i] & ~req_valid[i] & ~fin[i]) for an empty list.
//  req_last is ignored while fin[i] = 1, and it is never a transfer by itself.
//  req_ready is 0 in IDLE, DRAIN and DONE; pipe_in holds the null word in those states.
//  vsr: PIPE_LAT-bit shift register with vsr[0] <= pipe_in_valid. pipe_out_valid = vsr[PIPE_LAT-1].
//  Throughput: 1 pair/cycle sustained. Starvation-free: a continuously valid requester waits at most N_REQ-1 cycles.
//  start asserted outside IDLE is ignored. A start pulse held into DONE is not re-sampled until IDLE.
//  N_REQ = 1: arbiter degenerates to pass-through grant.
// CONFIGURATION
//  FORCE_SCHED_PAIRCNT_EN defined:
//   - Adds output pair_count[31:0], cleared on the IDLE->RUN transition.
//   - Increments on each grant and saturates at 32'hFFFF_FFFF.
//   - Holds its value after cell_done until the next start.
//  Not defined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package force_pkg holds:
//   - constants POS_W=96, ID_W=17, PAIR_W=227, NULL_BIT=226, and the REF_POS/REF_ID/NBR_POS/NBR_ID bit offsets;
//   - the null-word constant and the sched_state_t enum {IDLE, RUN, DRAIN, DONE}.
//  Sub-module rr_arbiter #(N): inputs eligible and ptr, outputs one-hot grant and gnt_idx; purely combinational.
//  FSM, fin[], vsr and the output registers live in force_pair_scheduler.
// TESTING
//  1. N_REQ=4, all valid continuously, none last -> grant order 0,1,2,3,0,...; pipe_in_valid=1 every cycle.
//  2. Requester 2 sends 3 pairs, last on the third; others assert last with valid=0 at start.
//     -> exactly 3 pipeline words with bit226=0; DRAIN; cell_done pulses PIPE_LAT+2 cycles after the 3rd grant.
//  3. Empty cell: start then all req_last=1 with valid=0 -> no valid pipe_in; cell_done 3 cycles after start; busy low after.
//  4. Latency: PIPE_LAT=3, single pair with ref id 17'h5, nbr id 17'hA.
//     -> pipe_out_valid high exactly 3 cycles after pipe_in_valid, for one cycle.
//  5. Reset asserted mid-RUN with 2 pairs in flight -> outputs asynchronously reach reset values; no cell_done.
//     -> next start grants from requester 0.
//  6. With FORCE_SCHED_PAIRCNT_EN: 7 granted pairs -> pair_count = 7 at cell_done; reads 0 the cycle after the next start.

Source files
------------

// File: rtl/force_pkg.sv
// rtl/force_pkg.sv - pair word layout, null word and scheduler state type
package force_pkg;

  localparam int POS_W    = 96;
  localparam int ID_W     = 17;
  localparam int REF_POS  = 0;
  localparam int REF_ID   = REF_POS + POS_W;
  localparam int NBR_POS  = REF_ID + ID_W;
  localparam int NBR_ID   = NBR_POS + POS_W;
  localparam int NULL_BIT = NBR_ID + ID_W;
  localparam int PAIR_W   = NULL_BIT + 1;

  // Idle pipeline slot: only the null flag set
  localparam logic [PAIR_W-1:0] NULL_WORD = {1'b1, {(PAIR_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

endpackage

// File: rtl/force_pair_scheduler_rr_arbiter.sv
// rtl/force_pair_scheduler_rr_arbiter.sv - combinational round-robin pick starting after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_idx
);

  int best;

  // Distance of requester i from the slot just after the last winner
  function automatic int rr_dist(input int i, input int p);
    return (i + N - 1 - p) % N;
  endfunction

  // Keep the eligible requester closest (in rotation order) to ptr+1
  always_comb begin
    grant   = '0;
    gnt_idx = ptr;
    best    = N;
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && (rr_dist(i, int'(ptr)) < best)) begin
        best     = rr_dist(i, int'(ptr));
        grant    = '0;
        grant[i] = 1'b1;
        gnt_idx  = IW'(i);
      end
    end
  end

endmodule

// File: rtl/force_pair_scheduler.sv
// rtl/force_pair_scheduler.sv - shares the LJ force pipeline among N_REQ pair filters; FORCE_SCHED_PAIRCNT_EN adds pair_count
module force_pair_scheduler
  import force_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int PIPE_LAT = 1,
  parameter int PAIR_W   = force_pkg::PAIR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*PAIR_W-1:0]   req_pair,
  output logic [N_REQ-1:0]          req_ready,
  output logic [PAIR_W-1:0]         pipe_in,
  output logic                      pipe_in_valid,
  output logic                      pipe_out_valid,
  output logic                      busy,
`ifdef FORCE_SCHED_PAIRCNT_EN
  output logic [31:0]               pair_count,
`endif
  output logic                      cell_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t          state_q, state_d;
  logic [N_REQ-1:0]      fin_q, fin_d;
  logic [PIPE_LAT-1:0]   vsr_q;
  logic [IW-1:0]         ptr_q;
  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      grant;
  logic [IW-1:0]         gnt_idx;
  logic [PAIR_W-1:0]     pair_sel;
  logic                  any_grant;

  // Only RUN may hand out grants; finished requesters drop out
  assign eligible  = (state_q == RUN) ? (req_valid & ~fin_q) : '0;
  assign any_grant = |grant;
  assign req_ready = grant;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .gnt_idx  (gnt_idx)
  );

  // Select the granted requester's pair word
  always_comb begin
    pair_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) pair_sel = req_pair[i*PAIR_W +: PAIR_W];
    end
  end

  // Next state of the cell sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (&fin_q) state_d = DRAIN;
      DRAIN:   if (vsr_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Finish flags: set on last transfer or on an empty list, cleared at cell start
  always_comb begin
    fin_d = fin_q;
    if (state_q == IDLE && start) begin
      fin_d = '0;
    end else if (state_q == RUN) begin
      fin_d = fin_q | (grant & req_last) | (req_last & ~req_valid & ~fin_q);
    end
  end

  // State, tracking and registered pipeline input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fin_q         <= '0;
      vsr_q         <= '0;
      ptr_q         <= IW'(N_REQ - 1);
      pipe_in       <= NULL_WORD;
      pipe_in_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= fin_d;
      vsr_q   <= (vsr_q << 1) | PIPE_LAT'(pipe_in_valid);
      if (any_grant) begin
        pipe_in       <= pair_sel & ~NULL_WORD;
        pipe_in_valid <= 1'b1;
        ptr_q         <= gnt_idx;
      end else begin
        pipe_in       <= NULL_WORD;
        pipe_in_valid <= 1'b0;
      end
    end
  end

  assign pipe_out_valid = vsr_q[PIPE_LAT-1];
  assign busy           = (state_q != IDLE);
  assign cell_done      = (state_q == DONE);

`ifdef FORCE_SCHED_PAIRCNT_EN
  // Grants in the current cell, saturating; held after the cell ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_count <= '0;
    end else if (state_q == IDLE && start) begin
      pair_count <= '0;
    end else if (any_grant && (pair_count != 32'hFFFF_FFFF)) begin
      pair_count <= pair_count + 32'd1;
    end
  end
`endif

endmodule
